// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the serial sequence detector. Words arrive over
// valid/ready into a one-word holding buffer and are shifted out one bit per clock.
module serial_word_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic               accept;
    logic               last_bit;

    // Ready is a pure decode of the buffer flag, so upstream never sees a
    // combinational path from its own valid back to ready.
    assign accept   = data_valid && !hold_full_q;
    assign last_bit = (bit_cnt_q == LAST_CNT);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples the
    // pre-edge value of its inputs regardless of statement order.
    // NOTE: the holding buffer is a plain register, not a memory array, so it is
    // reset along with everything else at no real cost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    // Next-state and datapath update.
    // NOTE: every signal driven here gets a default first; a missed branch would
    // otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shift_d = {1'b0, shift_q[WIDTH-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (hold_full_q) begin
                    // Gapless reload: next word's first bit follows immediately.
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accept needs an empty buffer and a transfer needs a full one, so the
        // two never collide on the same edge.
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    // Output decode.
    always_comb begin
        data_ready = !hold_full_q;
        busy       = (state_q == S_SHIFT) || hold_full_q;
        serial_out = IDLE_BIT;
        bit_valid  = 1'b0;
        frame_done = 1'b0;
        if (state_q == S_SHIFT) begin
            serial_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
            bit_valid  = 1'b1;
            frame_done = last_bit;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: an MSB-first and an LSB-first instance, each with
// a bit-level scoreboard fed when a word is driven and drained by a negedge monitor.
module tb_serial_word_feeder;

    logic       clk;
    logic       n_rst;

    logic [7:0] din_m, din_l;
    logic       dv_m, dv_l;
    logic       rdy_m, rdy_l;
    logic       so_m, so_l;
    logic       bv_m, bv_l;
    logic       fd_m, fd_l;
    logic       busy_m, busy_l;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t exp_m[$];
    exp_t exp_l[$];
    exp_t e_m, e_l;

    int n_cmp = 0;
    int n_err = 0;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .n_rst(n_rst), .data_in(din_m), .data_valid(dv_m),
        .data_ready(rdy_m), .serial_out(so_m), .bit_valid(bv_m),
        .frame_done(fd_m), .busy(busy_m)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .data_in(din_l), .data_valid(dv_l),
        .data_ready(rdy_l), .serial_out(so_l), .bit_valid(bv_l),
        .frame_done(fd_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitors: every valid bit must match the next expected bit and
    // its frame_done flag; idle cycles must show the idle level.
    always @(negedge clk) begin
        if (n_rst) begin
            n_cmp++;
            if (bv_m) begin
                if (exp_m.size() == 0) begin
                    n_err++;
                    $display("FAIL msb_extra_bit: got serial_out=%b with no bit expected", so_m);
                end else begin
                    e_m = exp_m.pop_front();
                    if (so_m !== e_m.b || fd_m !== e_m.last) begin
                        n_err++;
                        $display("FAIL msb_bit: got bit=%b frame_done=%b, expected bit=%b frame_done=%b",
                                 so_m, fd_m, e_m.b, e_m.last);
                    end
                end
            end else if (so_m !== 1'b0 || fd_m !== 1'b0) begin
                n_err++;
                $display("FAIL msb_idle: got serial_out=%b frame_done=%b, expected 0 0", so_m, fd_m);
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            n_cmp++;
            if (bv_l) begin
                if (exp_l.size() == 0) begin
                    n_err++;
                    $display("FAIL lsb_extra_bit: got serial_out=%b with no bit expected", so_l);
                end else begin
                    e_l = exp_l.pop_front();
                    if (so_l !== e_l.b || fd_l !== e_l.last) begin
                        n_err++;
                        $display("FAIL lsb_bit: got bit=%b frame_done=%b, expected bit=%b frame_done=%b",
                                 so_l, fd_l, e_l.b, e_l.last);
                    end
                end
            end else if (so_l !== 1'b0 || fd_l !== 1'b0) begin
                n_err++;
                $display("FAIL lsb_idle: got serial_out=%b frame_done=%b, expected 0 0", so_l, fd_l);
            end
        end
    end

    // Present a word, queue its expected bits, wait for ready, and return just
    // after the accepting edge with data_valid still high.
    task automatic send(input bit lsb, input logic [7:0] w);
        int t = 0;
        if (!lsb) begin
            din_m = w;
            dv_m  = 1'b1;
            for (int i = 7; i >= 0; i--) exp_m.push_back(exp_t'{b: w[i], last: (i == 0)});
            while (!rdy_m && t < 100) begin @(negedge clk); t++; end
        end else begin
            din_l = w;
            dv_l  = 1'b1;
            for (int i = 0; i < 8; i++) exp_l.push_back(exp_t'{b: w[i], last: (i == 7)});
            while (!rdy_l && t < 100) begin @(negedge clk); t++; end
        end
        n_cmp++;
        if (t >= 100) begin
            n_err++;
            $display("FAIL send_timeout: data_ready stayed 0 for %0d cycles, expected 1 within 100", t);
        end
        @(posedge clk);
        #1;
    endtask

    // Wait for the instance to go quiet with its scoreboard empty.
    task automatic drain(input bit lsb);
        int t = 0;
        if (!lsb) begin
            while ((busy_m || exp_m.size() > 0) && t < 200) begin @(negedge clk); t++; end
        end else begin
            while ((busy_l || exp_l.size() > 0) && t < 200) begin @(negedge clk); t++; end
        end
        n_cmp++;
        if (t >= 200) begin
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", t);
        end
        n_cmp++;
        if (( lsb && (bv_l !== 1'b0 || rdy_l !== 1'b1)) ||
            (!lsb && (bv_m !== 1'b0 || rdy_m !== 1'b1))) begin
            n_err++;
            $display("FAIL drain_state: got bit_valid/ready=%b%b, expected 01",
                     lsb ? bv_l : bv_m, lsb ? rdy_l : rdy_m);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        din_m = '0; dv_m = 1'b0;
        din_l = '0; dv_l = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rdy_m, so_m, bv_m, fd_m, busy_m} !== 5'b10000 ||
            {rdy_l, so_l, bv_l, fd_l, busy_l} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_outputs: got msb=%b lsb=%b, expected 10000 10000",
                     {rdy_m, so_m, bv_m, fd_m, busy_m}, {rdy_l, so_l, bv_l, fd_l, busy_l});
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        send(1'b0, 8'hD0);
        dv_m = 1'b0;
        // Accepted, not yet transferred: buffered but no bit on the line.
        n_cmp++;
        if (bv_m !== 1'b0 || busy_m !== 1'b1 || rdy_m !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency0: got bit_valid/busy/ready=%b%b%b, expected 010", bv_m, busy_m, rdy_m);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bv_m !== 1'b1 || so_m !== 1'b1 || rdy_m !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency1: got bit_valid/serial/ready=%b%b%b, expected 111", bv_m, so_m, rdy_m);
        end
        drain(1'b0);
    endtask

    task automatic test_back_to_back();
        send(1'b0, 8'hA5);
        send(1'b0, 8'h3C);
        n_cmp++;
        if (rdy_m !== 1'b0 || busy_m !== 1'b1 || bv_m !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_buffered: got ready/busy/bit_valid=%b%b%b, expected 011", rdy_m, busy_m, bv_m);
        end
        dv_m = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_lsb_first();
        send(1'b1, 8'h0B);
        dv_l = 1'b0;
        drain(1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] words [3] = '{8'h96, 8'h5A, 8'hE1};
        for (int k = 0; k < 3; k++) begin
            send(1'b0, words[k]);
            n_cmp++;
            if (rdy_m !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready_word%0d: got data_ready=%b, expected 0", k, rdy_m);
            end
        end
        dv_m = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_mid_reset();
        send(1'b0, 8'hFF);
        send(1'b0, 8'h77);
        dv_m = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({rdy_m, so_m, bv_m, fd_m, busy_m} !== 5'b10000) begin
            n_err++;
            $display("FAIL midreset_async: got ready/serial/bv/fd/busy=%b, expected 10000",
                     {rdy_m, so_m, bv_m, fd_m, busy_m});
        end
        exp_m.delete();
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bv_m !== 1'b0 || busy_m !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_leftover: cycle %0d got bit_valid/busy=%b%b, expected 00", c, bv_m, busy_m);
            end
        end
        send(1'b0, 8'h4B);
        dv_m = 1'b0;
        drain(1'b0);
    endtask

    task automatic test_idle_gap();
        send(1'b0, 8'h80);
        dv_m = 1'b0;
        drain(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (so_m !== 1'b0 || bv_m !== 1'b0) begin
                n_err++;
                $display("FAIL gap_idle: cycle %0d got serial/bit_valid=%b%b, expected 00", c, so_m, bv_m);
            end
        end
        send(1'b0, 8'h01);
        dv_m = 1'b0;
        n_cmp++;
        if (bv_m !== 1'b0) begin
            n_err++;
            $display("FAIL gap_latency0: got bit_valid=%b, expected 0", bv_m);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bv_m !== 1'b1 || so_m !== 1'b0) begin
            n_err++;
            $display("FAIL gap_latency1: got bit_valid/serial=%b%b, expected 10", bv_m, so_m);
        end
        drain(1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_backpressure();
        test_mid_reset();
        test_idle_gap();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
